// File: rtl/med_win_linebuf.sv
// Three-row raster line buffer producing vertically aligned pixel triplets
// (row r-2, r-1, r) for the downstream 3-input median stage.
module med_win_linebuf #(
   parameter int unsigned DW    = 3,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned CW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          din_vld,
   input  logic [DW-1:0] din,
   input  logic          din_sof,
   output logic [DW-1:0] tap0,
   output logic [DW-1:0] tap1,
   output logic [DW-1:0] tap2,
   output logic          tap_vld,
   output logic [CW-1:0] tap_col,
   output logic [CW-1:0] tap_row,
   output logic          frame_done
);

   localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CW-1:0] LAST_COL    = CW'(IMG_W - 1);
   localparam logic [CW-1:0] LAST_ROW    = CW'(IMG_H - 1);
   localparam logic [CW-1:0] STREAM_ROW  = CW'(2);

   logic [CW-1:0] col_cnt;
   logic [CW-1:0] row_cnt;

   // lb0 holds row r-1, lb1 holds row r-2; not reset, exposure gated by row
   logic [DW-1:0] lb0 [IMG_W];
   logic [DW-1:0] lb1 [IMG_W];

   logic [CW-1:0] eff_col_c;
   logic [CW-1:0] eff_row_c;
   logic [AW-1:0] addr_c;
   logic          last_col_c;
   logic          last_row_c;
   logic          stream_c;
   logic [DW-1:0] old0_c;
   logic [DW-1:0] old1_c;

   // din_sof resyncs the effective position to (0,0) for its own pixel
   always_comb begin
      eff_col_c  = din_sof ? '0 : col_cnt;
      eff_row_c  = din_sof ? '0 : row_cnt;
      addr_c     = eff_col_c[AW-1:0];
      last_col_c = (eff_col_c == LAST_COL);
      last_row_c = (eff_row_c == LAST_ROW);
      stream_c   = (eff_row_c >= STREAM_ROW);
      old0_c     = lb0[addr_c];
      old1_c     = lb1[addr_c];
   end

   // Read-before-write shift of the column down through both line memories
   always_ff @(posedge clk) begin
      if (din_vld) begin
         lb0[addr_c] <= din;
         lb1[addr_c] <= old0_c;
      end
   end

   // Raster position counters; wrap at frame end starts an implicit new frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (din_vld) begin
         if (last_col_c) begin
            col_cnt <= '0;
            row_cnt <= last_row_c ? '0 : eff_row_c + CW'(1);
         end else begin
            col_cnt <= eff_col_c + CW'(1);
            row_cnt <= eff_row_c;
         end
      end
   end

   // Registered triplet and sideband; taps hold across input gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap0       <= '0;
         tap1       <= '0;
         tap2       <= '0;
         tap_col    <= '0;
         tap_row    <= '0;
         tap_vld    <= 1'b0;
         frame_done <= 1'b0;
      end else if (din_vld) begin
         tap0       <= old1_c;
         tap1       <= old0_c;
         tap2       <= din;
         tap_col    <= eff_col_c;
         tap_row    <= eff_row_c;
         tap_vld    <= stream_c;
         frame_done <= last_row_c && last_col_c;
      end else begin
         tap_vld    <= 1'b0;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_med_win_linebuf.sv
// Directed self-checking bench for med_win_linebuf on a 4x4, 3-bit image.
module tb_med_win_linebuf;

   localparam int unsigned DW = 3;
   localparam int unsigned IW = 4;
   localparam int unsigned IH = 4;
   localparam int unsigned CW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          din_vld;
   logic [DW-1:0] din;
   logic          din_sof;
   logic [DW-1:0] tap0, tap1, tap2;
   logic          tap_vld;
   logic [CW-1:0] tap_col, tap_row;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   med_win_linebuf #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .din_sof(din_sof),
      .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap_vld(tap_vld),
      .tap_col(tap_col), .tap_row(tap_row), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'((r * 4 + c) & 7);
   endfunction

   // {vld, frame_done, row, col, tap2}
   function automatic logic [24:0] exp_short(input int r, input int c, input logic v);
      return {v, 1'b0, CW'(r), CW'(c), pix(r, c)};
   endfunction

   // {vld, frame_done, row, col, tap0, tap1, tap2} for a streaming pixel
   function automatic logic [30:0] exp_full(input int r, input int c);
      logic fd;
      fd = (r == IH - 1) && (c == IW - 1);
      return {1'b1, fd, CW'(r), CW'(c), pix(r - 2, c), pix(r - 1, c), pix(r, c)};
   endfunction

   // Drive one cycle of input, then sample one time unit after the edge
   task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
      @(negedge clk);
      din_vld = v;
      din_sof = s;
      din     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; din_vld = 1'b0; din_sof = 1'b0; din = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({tap0, tap1, tap2, tap_vld, tap_col, tap_row, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {tap0, tap1, tap2, tap_vld, tap_col, tap_row, frame_done});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_frame;
      int nv = 0;
      for (int i = 0; i < 16; i++) begin
         int r = i / 4;
         int c = i % 4;
         step(1'b1, i == 0, pix(r, c));
         nv += int'(tap_vld);
         checks++;
         if (r >= 2) begin
            if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(r, c)) begin
               errors++;
               $display("FAIL frame_r%0d_c%0d: got %h required %h", r, c,
                        {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(r, c));
            end
         end else if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL frame_fill_r%0d_c%0d: got %h required %h", r, c,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
      end
      checks++;
      if (nv != 8) begin
         errors++;
         $display("FAIL frame_vld_count: got %0d required 8", nv);
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if ({tap_vld, frame_done, tap2} !== {2'b00, pix(3, 3)}) begin
         errors++;
         $display("FAIL frame_idle_hold: got %h required %h",
                  {tap_vld, frame_done, tap2}, {2'b00, pix(3, 3)});
      end
   endtask

   task automatic test_gaps;
      for (int i = 0; i < 16; i++) begin
         int r = i / 4;
         int c = i % 4;
         step(1'b1, i == 0, pix(r, c));
         checks++;
         if (r >= 2) begin
            if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(r, c)) begin
               errors++;
               $display("FAIL gaps_r%0d_c%0d: got %h required %h", r, c,
                        {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(r, c));
            end
         end else if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL gaps_fill_r%0d_c%0d: got %h required %h", r, c,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
         step(1'b0, 1'b0, 3'd6);
         checks++;
         if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL gaps_idle_r%0d_c%0d: got %h required %h", r, c,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
      end
   endtask

   task automatic test_back_to_back;
      int nv = 0;
      for (int i = 0; i < 32; i++) begin
         int r = (i / 4) % 4;
         int c = i % 4;
         step(1'b1, i == 0, pix(r, c));
         nv += int'(tap_vld);
         checks++;
         if (r >= 2) begin
            if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(r, c)) begin
               errors++;
               $display("FAIL b2b_%0d_r%0d_c%0d: got %h required %h", i / 16, r, c,
                        {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(r, c));
            end
         end else if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL b2b_fill_%0d_r%0d_c%0d: got %h required %h", i / 16, r, c,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
      end
      checks++;
      if (nv != 16) begin
         errors++;
         $display("FAIL b2b_vld_count: got %0d required 16", nv);
      end
      step(1'b0, 1'b0, '0);
   endtask

   task automatic test_sof_mid;
      for (int i = 0; i < 10; i++) step(1'b1, i == 0, pix(i / 4, i % 4));
      step(1'b1, 1'b1, pix(0, 0));
      checks++;
      if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(0, 0, 1'b0)) begin
         errors++;
         $display("FAIL sof_mid_resync: got %h required %h",
                  {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(0, 0, 1'b0));
      end
      for (int k = 1; k <= 8; k++) begin
         int r = k / 4;
         int c = k % 4;
         step(1'b1, 1'b0, pix(r, c));
         checks++;
         if (k == 8) begin
            if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(r, c)) begin
               errors++;
               $display("FAIL sof_mid_first_vld: got %h required %h",
                        {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(r, c));
            end
         end else if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL sof_mid_fill_%0d: got %h required %h", k,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
      end
      step(1'b0, 1'b0, '0);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 14; i++) step(1'b1, i == 0, pix(i / 4, i % 4));
      @(negedge clk);
      din_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tap0, tap1, tap2, tap_vld, tap_col, tap_row, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: got %h required 0",
                  {tap0, tap1, tap2, tap_vld, tap_col, tap_row, frame_done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         int r = k / 4;
         int c = k % 4;
         step(1'b1, 1'b0, pix(r, c));
         checks++;
         if (k == 8) begin
            if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(r, c)) begin
               errors++;
               $display("FAIL reset_mid_first_vld: got %h required %h",
                        {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(r, c));
            end
         end else if ({tap_vld, frame_done, tap_row, tap_col, tap2} !== exp_short(r, c, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_fill_%0d: got %h required %h", k,
                     {tap_vld, frame_done, tap_row, tap_col, tap2}, exp_short(r, c, 1'b0));
         end
      end
      step(1'b0, 1'b0, '0);
   endtask

   task automatic test_sof_idle;
      for (int i = 0; i < 9; i++) step(1'b1, i == 0, pix(i / 4, i % 4));
      step(1'b0, 1'b1, 3'd5);
      checks++;
      if ({tap_vld, frame_done} !== 2'b00) begin
         errors++;
         $display("FAIL sof_idle_gap: got %b required 00", {tap_vld, frame_done});
      end
      step(1'b1, 1'b0, pix(2, 1));
      checks++;
      if ({tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2} !== exp_full(2, 1)) begin
         errors++;
         $display("FAIL sof_idle_next: got %h required %h",
                  {tap_vld, frame_done, tap_row, tap_col, tap0, tap1, tap2}, exp_full(2, 1));
      end
      step(1'b0, 1'b0, '0);
   endtask

   initial begin
      test_reset;
      test_frame;
      test_gaps;
      test_back_to_back;
      test_sof_mid;
      test_reset_mid;
      test_sof_idle;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
